// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause encoding and
// a counter-width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        RUN   = 2'd2
    } rst_state_t;

    typedef enum logic [1:0] {
        CAUSE_POR    = 2'd0,
        CAUSE_BUTTON = 2'd1,
        CAUSE_WDOG   = 2'd2,
        CAUSE_SOFT   = 2'd3
    } rst_cause_t;

    // Counter width for a count of n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, debounced
// level and a single-cycle pulse on each accepted press (falling level).
module btn_debounce
    import rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic RST_n,
    input  logic btn_n,
    output logic press
);

    localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // Counter only advances while the synced input disagrees with the accepted
    // level; any agreement restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/rst_sequencer.sv
// Reset generator/sequencer: merges board reset, button, soft request and the
// optional watchdog (macro RST_SEQ_WATCHDOG_EN) into staged domain releases.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS     = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_GAP       = 4,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int WDOG_CYCLES     = 2**20
) (
    input  logic                   clk,
    input  logic                   RST_n,
    input  logic                   btn_n,
    input  logic                   soft_rst_req,
    input  logic                   wdog_kick,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   rst_busy,
    output logic [1:0]             rst_cause
);

    localparam int            HW        = cnt_w(HOLD_CYCLES);
    localparam int            GW        = cnt_w(STAGE_GAP);
    localparam int            IW        = cnt_w(NUM_DOMAINS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

    logic                   rel_meta_q;
    logic                   rel_sync_q;
    logic                   btn_press;
    logic                   wdog_evt;

    rst_state_t             state_q, state_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_out_q, rst_n_out_d;
    logic                   rst_busy_q, rst_busy_d;
    rst_cause_t             cause_q, cause_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .RST_n (RST_n),
        .btn_n (btn_n),
        .press (btn_press)
    );

    // Release of the board reset is re-timed to clk before the FSM may move.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            rel_meta_q <= 1'b0;
            rel_sync_q <= 1'b0;
        end else begin
            rel_meta_q <= 1'b1;
            rel_sync_q <= rel_meta_q;
        end
    end

`ifdef RST_SEQ_WATCHDOG_EN
    localparam int            WW        = cnt_w(WDOG_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;

    always_comb begin
        wdog_cnt_d = '0;
        if (state_q == RUN && !wdog_kick && wdog_cnt_q != WDOG_LAST)
            wdog_cnt_d = wdog_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) wdog_cnt_q <= '0;
        else        wdog_cnt_q <= wdog_cnt_d;
    end

    assign wdog_evt = (state_q == RUN) && (wdog_cnt_q == WDOG_LAST);
`else
    localparam int unused_wdog_cycles = WDOG_CYCLES;
    logic unused_wdog_kick;
    assign unused_wdog_kick = wdog_kick;
    assign wdog_evt         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        idx_d       = idx_q;
        rst_n_out_d = rst_n_out_q;
        rst_busy_d  = rst_busy_q;
        cause_d     = cause_q;
        if (rel_sync_q) begin
            if (btn_press || wdog_evt || soft_rst_req) begin
                // Any event restarts the whole sequence, whatever the state.
                if (btn_press)     cause_d = CAUSE_BUTTON;
                else if (wdog_evt) cause_d = CAUSE_WDOG;
                else               cause_d = CAUSE_SOFT;
                state_d     = HOLD;
                hold_cnt_d  = '0;
                gap_cnt_d   = '0;
                idx_d       = '0;
                rst_n_out_d = '0;
                rst_busy_d  = 1'b1;
            end else begin
                case (state_q)
                    HOLD: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            hold_cnt_d     = '0;
                            rst_n_out_d[0] = 1'b1;
                            if (NUM_DOMAINS == 1) begin
                                state_d    = RUN;
                                rst_busy_d = 1'b0;
                            end else begin
                                state_d = STAGE;
                                idx_d   = IW'(1);
                            end
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    STAGE: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            gap_cnt_d          = '0;
                            rst_n_out_d[idx_q] = 1'b1;
                            if (idx_q == IDX_LAST) begin
                                state_d    = RUN;
                                rst_busy_d = 1'b0;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end else begin
                            gap_cnt_d = gap_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            idx_q       <= '0;
            rst_n_out_q <= '0;
            rst_busy_q  <= 1'b1;
            cause_q     <= CAUSE_POR;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            idx_q       <= idx_d;
            rst_n_out_q <= rst_n_out_d;
            rst_busy_q  <= rst_busy_d;
            cause_q     <= cause_d;
        end
    end

    assign rst_n_out = rst_n_out_q;
    assign rst_busy  = rst_busy_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: POR, async re-assert, soft reset, button
// bounce/short press, button+soft collision and watchdog behaviour.
module tb_rst_sequencer;

    logic       clk = 1'b0;
    logic       RST_n = 1'b0;
    logic       btn_n = 1'b1;
    logic       soft_rst_req = 1'b0;
    logic       wdog_kick = 1'b0;
    logic [2:0] rst_n_out;
    logic       rst_busy;
    logic [1:0] rst_cause;

    int n_assert = 0;
    int n_fail   = 0;
    logic [2:0] exp3;

    rst_sequencer #(
        .NUM_DOMAINS     (3),
        .HOLD_CYCLES     (16),
        .STAGE_GAP       (4),
        .DEBOUNCE_CYCLES (8),
        .WDOG_CYCLES     (100)
    ) dut (
        .clk          (clk),
        .RST_n        (RST_n),
        .btn_n        (btn_n),
        .soft_rst_req (soft_rst_req),
        .wdog_kick    (wdog_kick),
        .rst_n_out    (rst_n_out),
        .rst_busy     (rst_busy),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edge 1 is the first rise with RST_n high; domain k releases after edge 18+4k.
    task automatic por_seq();
        @(negedge clk);
        RST_n = 1'b1;
        for (int e = 1; e <= 28; e++) begin
            step();
            exp3 = {e >= 26, e >= 22, e >= 18};
            chk($sformatf("por_out_e%0d", e), 32'(rst_n_out), 32'(exp3));
            chk($sformatf("por_busy_e%0d", e), 32'(rst_busy), 32'(e < 26));
        end
        chk("por_cause", 32'(rst_cause), 32'd0);
    endtask

    initial begin
        // Held in reset with clocks running: nothing may move.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out", 32'(rst_n_out), 32'd0);
            chk("rst_busy", 32'(rst_busy), 32'd1);
            chk("rst_cause", 32'(rst_cause), 32'd0);
        end

        por_seq();

        // Soft reset sampled at edge n (j=0); domain 0 back after edge n+16.
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        chk("soft_out", 32'(rst_n_out), 32'd0);
        chk("soft_busy", 32'(rst_busy), 32'd1);
        chk("soft_cause", 32'(rst_cause), 32'd3);
        for (int j = 1; j <= 18; j++) begin
            step();
            chk($sformatf("soft_out_j%0d", j), 32'(rst_n_out), 32'(j >= 16));
        end

        // Mid-STAGE async assert between edges: immediate clear, cause back to POR.
        #3;
        RST_n = 1'b0;
        #1;
        chk("async_out", 32'(rst_n_out), 32'd0);
        chk("async_busy", 32'(rst_busy), 32'd1);
        chk("async_cause", 32'(rst_cause), 32'd0);
        step();
        step();
        chk("async_hold_out", 32'(rst_n_out), 32'd0);
        por_seq();

        // Bouncing button (3 low / 3 high) never stays stable for 8 cycles.
        for (int t = 0; t < 24; t++) begin
            btn_n = 1'((t / 3) % 2);
            step();
            chk($sformatf("bounce_out_t%0d", t), 32'(rst_n_out), 32'd7);
        end

        // Low from edge 1: synced after 2, accepted after 10, response after 11.
        for (int i = 1; i <= 36; i++) begin
            btn_n = (i > 20);
            step();
            exp3 = (i <= 10) ? 3'b111 : {i >= 35, i >= 31, i >= 27};
            chk($sformatf("press_out_i%0d", i), 32'(rst_n_out), 32'(exp3));
            if (i == 11) chk("press_cause", 32'(rst_cause), 32'd1);
            if (i == 34) chk("press_busy_hi", 32'(rst_busy), 32'd1);
            if (i == 35) chk("press_busy_lo", 32'(rst_busy), 32'd0);
        end

        // A 5-cycle press is too short to be accepted.
        for (int j = 1; j <= 20; j++) begin
            btn_n = (j > 5);
            step();
            chk($sformatf("short_out_j%0d", j), 32'(rst_n_out), 32'd7);
            chk($sformatf("short_busy_j%0d", j), 32'(rst_busy), 32'd0);
        end

        // Soft at i=0, then button (low from i=8) and soft both land on edge 18 mid-STAGE.
        for (int i = 0; i <= 42; i++) begin
            soft_rst_req = (i == 0) || (i == 18);
            btn_n        = !(i >= 8 && i <= 24);
            step();
            case (i)
                0: begin
                    chk("coll_soft_out", 32'(rst_n_out), 32'd0);
                    chk("coll_soft_cause", 32'(rst_cause), 32'd3);
                end
                15: chk("coll_out_15", 32'(rst_n_out), 32'd0);
                16: chk("coll_out_16", 32'(rst_n_out), 32'd1);
                17: chk("coll_out_17", 32'(rst_n_out), 32'd1);
                18: begin
                    chk("coll_out_18", 32'(rst_n_out), 32'd0);
                    chk("coll_busy_18", 32'(rst_busy), 32'd1);
                    chk("coll_cause", 32'(rst_cause), 32'd1);
                end
                33: chk("coll_out_33", 32'(rst_n_out), 32'd0);
                34: chk("coll_out_34", 32'(rst_n_out), 32'd1);
                42: begin
                    chk("coll_out_42", 32'(rst_n_out), 32'd7);
                    chk("coll_busy_42", 32'(rst_busy), 32'd0);
                end
                default: ;
            endcase
        end
        soft_rst_req = 1'b0;
        btn_n        = 1'b1;

        // Kicks every 50 cycles keep the sequencer in RUN.
        for (int j = 1; j <= 300; j++) begin
            wdog_kick = ((j % 50) == 1);
            step();
            chk($sformatf("kick_busy_j%0d", j), 32'(rst_busy), 32'd0);
        end

        // Last kick at j=0, then none: expiry sampled at edge j=100.
        wdog_kick = 1'b1;
        step();
        wdog_kick = 1'b0;
        for (int j = 1; j <= 120; j++) begin
            step();
`ifdef RST_SEQ_WATCHDOG_EN
            if (j <= 100)
                chk($sformatf("wdog_busy_j%0d", j), 32'(rst_busy), 32'(j >= 100));
            if (j == 100) chk("wdog_out", 32'(rst_n_out), 32'd0);
`else
            chk($sformatf("nowdog_busy_j%0d", j), 32'(rst_busy), 32'd0);
            chk($sformatf("nowdog_out_j%0d", j), 32'(rst_n_out), 32'd7);
`endif
        end
`ifdef RST_SEQ_WATCHDOG_EN
        chk("wdog_cause", 32'(rst_cause), 32'd2);
`else
        chk("nowdog_cause", 32'(rst_cause), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Reset generator and sequencer for the robot top level. It turns the board reset, a debounced push-button, a firmware soft-reset request and an optional watchdog into one stretched reset event. It then releases a set of reset domains in a fixed order, staggered in time. Each `rst_n_out` bit drives a domain's reset input, and the released reset is glitch-free and synchronous to `clk`.

## Interface
- `NUM_DOMAINS`, default 3: number of staged reset outputs, minimum 1.
- `HOLD_CYCLES`, default 16: minimum number of `clk` cycles all domains are held in reset, minimum 2.
- `STAGE_GAP`, default 4: cycles between consecutive domain releases, minimum 1.
- `DEBOUNCE_CYCLES`, default 1024: number of cycles the button level must be stable to be accepted.
- `WDOG_CYCLES`, default 2**20: watchdog timeout in cycles.
- `clk` in 1: system clock.
- `RST_n` in 1: reset, asynchronous, active-low.
- `btn_n` in 1: raw push-button, active-low, asynchronous to `clk`.
- `soft_rst_req` in 1: single-cycle synchronous soft-reset request.
- `wdog_kick` in 1: synchronous watchdog restart pulse.
- `rst_n_out` out `NUM_DOMAINS`: per-domain reset, active-low; bit 0 is released first.
- `rst_busy` out 1: high while any domain is held in reset.
- `rst_cause` out 2: cause of the last reset. 0 = POR, 1 = BUTTON, 2 = WDOG, 3 = SOFT.

## Operation
- **`RST_n` low:** everything is forced immediately and asynchronously:
  - `rst_n_out` = 0, `rst_busy` = 1, `rst_cause` = 0;
  - state = HOLD, hold/stage counters = 0;
  - debouncer level = released, watchdog counter = 0.
- **Reset release:** the rising edge of `RST_n` passes through an internal 2-flop synchronizer (`rel_sync`). It is asynchronously cleared and shifts in 1. The FSM does not advance until `rel_sync` = 1.
- **HOLD:**
  - Count up each cycle.
  - At count `HOLD_CYCLES`-1, go to STAGE, release `rst_n_out[0]`, and clear the counter.
- **STAGE:**
  - Count up each cycle; at count `STAGE_GAP`-1, release the next domain.
  - After bit `NUM_DOMAINS`-1 is released, go to RUN.
  - If `NUM_DOMAINS` = 1, go from HOLD directly to RUN.
- **RUN:** all outputs are 1 and `rst_busy` = 0.
- **Reset event:** one of the following, sampled in any state once `rel_sync` = 1:
  - a debounced button press (falling edge of the debounced level);
  - a `soft_rst_req` pulse;
  - a watchdog expiry.
- **Response to an event** (registered, one edge):
  - all `rst_n_out` go to 0 and `rst_busy` goes to 1;
  - state goes to HOLD with the counter at 0;
  - `rst_cause` is updated.
- **Event during HOLD or STAGE:** the hold period restarts from 0, and any domains already released are re-asserted.
- **Simultaneous events:** priority is BUTTON > WDOG > SOFT. `rst_cause` records the winner.
- **Button held down:** produces exactly one event per press. A release followed by a new stable press is required for another event.
- **Counter widths:** `$clog2` of the parameter, with a minimum of 1 bit. Counters never wrap, because each one is cleared at its terminal count.

## Timing
- **Edge numbering:** edge 1 is the first `clk` rise with `RST_n` = 1. `rel_sync` = 1 after edge 2.
- **POR release times:**
  - `rst_n_out[k]` rises after edge 2+`HOLD_CYCLES`+k*`STAGE_GAP`;
  - `rst_busy` falls on the same edge as the last domain release.
- **Event sampled at edge n:**
  - all outputs are low after edge n;
  - `rst_n_out[0]` rises after edge n+`HOLD_CYCLES`.
- **Button latency:** 2 synchronizer cycles plus `DEBOUNCE_CYCLES` of stability before the event is generated.
- **Output glitches:** outputs are driven directly from flops, with no combinational glitch.

## Configuration
- `RST_SEQ_WATCHDOG_EN` defined:
  - the watchdog counter runs only in RUN and is cleared by `wdog_kick` or on leaving RUN;
  - when the counter reaches `WDOG_CYCLES`-1 in RUN, a WDOG event is raised.
- `RST_SEQ_WATCHDOG_EN` undefined:
  - no watchdog counter is built and `wdog_kick` is ignored;
  - `rst_cause` is never 2.

## Structure
- **Package `rst_seq_pkg`:**
  - state enum `rst_state_t` (HOLD, STAGE, RUN);
  - cause enum `rst_cause_t` (CAUSE_POR, CAUSE_BUTTON, CAUSE_WDOG, CAUSE_SOFT).
- **Sub-module `btn_debounce`:**
  - contains the 2-flop synchronizer, stability counter, debounced level and single-cycle press pulse;
  - parameterized by `DEBOUNCE_CYCLES`.

## Test plan
All scenarios use `NUM_DOMAINS`=3, `HOLD_CYCLES`=16, `STAGE_GAP`=4, `DEBOUNCE_CYCLES`=8 and `WDOG_CYCLES`=100.
- **POR:** release `RST_n`. Expect:
  - `rst_n_out` bits rise after edges 18, 22 and 26;
  - `rst_busy` falls at edge 26;
  - `rst_cause` = 0.
- **Async assert:** pulse `RST_n` low mid-STAGE, between clock edges. Expect all outputs to go to 0 immediately, then the full POR sequence to repeat.
- **Soft reset:** pulse `soft_rst_req` in RUN at edge n. Expect:
  - all outputs 0 after edge n;
  - `rst_n_out[0]` high after edge n+16;
  - `rst_cause` = 3.
- **Button bounce:**
  - `btn_n` toggling every 3 cycles, then held low for 20 cycles: expect exactly one event, with `rst_cause` = 1;
  - `btn_n` low for only 5 cycles: expect no event.
- **Collision:** button press and `soft_rst_req` arrive on the same edge during STAGE. Expect:
  - domain 0 re-asserted and the hold count restarted;
  - `rst_cause` = 1.
- **Watchdog** (with `RST_SEQ_WATCHDOG_EN`):
  - no kick for 100 cycles in RUN: expect a reset with `rst_cause` = 2;
  - kick every 50 cycles: expect no reset.
  - Without the macro: expect no reset ever.
